multicycle_controller: RTL

- Moore/Mealy FSM that sequences the shared-memory multi-cycle MIPS datapath: one ALU, one unified instruction/data memory, one register file, with IR/PC/MDR/A/B/ALUOut registers.
- Decodes the opcode and steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Handles the memory ready handshake with a bounded wait.
- Emits per-cycle datapath control strobes.

---
 rtl/mc_pkg.sv | 41 ++++
 rtl/mc_mem_wait_timer.sv | 39 +++
 rtl/multicycle_controller.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
// Holds the FSM state encoding, the opcode constants, the ALU operation and
// ALU B-operand select encodings, and the PC source encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EX_R,
    EX_ADR,
    EX_BEQ,
    EX_IMM,
    MEM_RD,
    MEM_WR,
    WB_R,
    WB_MEM,
    WB_IMM,
    HALT
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b000100;
  localparam logic [5:0] OP_SW   = 6'b000101;
  localparam logic [5:0] OP_BEQ  = 6'b000110;
  localparam logic [5:0] OP_ADDI = 6'b000111;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b011;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_BRANCH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Bounded-wait timer for memory handshakes.
// Counts consecutive cycles a memory state spends without mem_ready and
// flags a timeout once the count has reached WAIT_LIMIT and ready is still low.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   active    - controller is in a state that is waiting on memory
//   ready     - memory completed the current access this cycle
//   timeout   - combinational; high in the cycle the wait bound is exceeded
module mc_mem_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

  logic [CNT_W-1:0] count;

  // A ready in the limit cycle wins, so ready masks the timeout.
  assign timeout = active && !ready && (count == LIMIT);

  // Leaving or completing a memory access clears the count, so every memory
  // state starts its wait from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!active || ready) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory multi-cycle MIPS datapath.
// Steps each instruction through fetch, decode, execute, memory and
// write-back, waits on the memory handshake with a bounded timeout, and
// drives the per-cycle datapath strobes.
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   opcode          - IR[31:26], valid from DECODE onward
//   zero, mem_ready - ALU zero flag, memory access complete
//   pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
//   pc_source       - datapath control strobes and selects
//   illegal_op      - pulse on an unrecognised opcode
//   bus_error       - sticky memory timeout flag
//   instr_done      - pulse on the last cycle of a completed instruction
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       bus_error,
  output logic       instr_done
);

  state_t state;
  state_t next_state;
  logic   mem_active;
  logic   timeout;

  // The branch decision is made by the datapath through pc_write_cond, so
  // the controller itself never looks at the zero flag.
  logic unused_zero;
  assign unused_zero = zero;

  assign mem_active = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

  mc_mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .CNT_W     (CNT_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .active (mem_active),
    .ready  (mem_ready),
    .timeout(timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_error <= 1'b0;
    end else if (timeout) begin
      bus_error <= 1'b1;
    end
  end

  // Next-state and strobe decode. Fetch strobes for IR/PC follow mem_ready
  // directly so the PC increment lands in the same cycle the word arrives.
  always_comb begin
    next_state    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_RTYPE;
    pc_source     = PC_SRC_ALU;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;

    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          next_state = DECODE;
        end else if (timeout) begin
          next_state = HALT;
        end
      end
      DECODE: begin
        alu_src_b = SRC_B_BRANCH;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_R:             next_state = EX_R;
          OP_LW, OP_SW:     next_state = EX_ADR;
          OP_BEQ:           next_state = EX_BEQ;
          OP_ADDI, OP_SLTI: next_state = EX_IMM;
          default: begin
            illegal_op = 1'b1;
            next_state = FETCH;
          end
        endcase
      end
      EX_R: begin
        alu_src_a  = 1'b1;
        next_state = WB_R;
      end
      EX_ADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_ADD;
        next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      EX_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
        instr_done    = 1'b1;
        next_state    = FETCH;
      end
      EX_IMM: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        next_state = WB_IMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          next_state = WB_MEM;
        end else if (timeout) begin
          next_state = HALT;
        end
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          next_state = FETCH;
        end else if (timeout) begin
          next_state = HALT;
        end
      end
      WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      WB_IMM: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = FETCH;
      end
    endcase

    // Reset already forces FETCH, but FETCH requests memory; squash every
    // strobe so nothing reaches the datapath while reset is held.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
      instr_done    = 1'b0;
    end
  end

endmodule
